// File: rtl/fcvt_sched.sv
// Round-robin front end for a shared int<->float converter: registered issue,
// fixed-latency tag tracking, and a registered per-requester response.
module fcvt_sched #(
  parameter int NREQ    = 2,
  parameter int CVT_LAT = 0,
  parameter int TAGW    = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_op,
  input  logic [32*NREQ-1:0]   req_x,
  input  logic [TAGW*NREQ-1:0] req_tag,
  input  logic                 flush,
  output logic                 cvt_issue,
  output logic                 cvt_op,
  output logic [31:0]          cvt_x,
  input  logic [31:0]          cvt_y,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_y,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 idle
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_gnt_any;
  int              w_idx;
  logic [NREQ-1:0] w_ready;
  logic            w_sel_op;
  logic [31:0]     w_sel_x;
  logic [TAGW-1:0] w_sel_tag;

  // Scan from r_ptr upward (mod NREQ); reset and flush suppress any grant.
  always_comb begin
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_gnt_any && req_valid[IDW'(w_idx)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDW'(w_idx);
      end
    end
    if (flush || rstn) w_gnt_any = 1'b0;
  end

  always_comb begin
    w_ready   = '0;
    w_sel_op  = 1'b0;
    w_sel_x   = '0;
    w_sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == IDW'(i)) begin
        w_ready[i] = w_gnt_any;
        w_sel_op   = req_op[i];
        w_sel_x    = req_x[32*i +: 32];
        w_sel_tag  = req_tag[TAGW*i +: TAGW];
      end
    end
  end

  assign req_ready = w_ready;

  logic            r_iss_vld;
  logic            r_iss_op;
  logic [31:0]     r_iss_x;
  logic [TAGW-1:0] r_iss_tag;
  logic [IDW-1:0]  r_iss_id;

  // Issue register; a grant already implies no flush this cycle.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_ptr     <= '0;
      r_iss_vld <= 1'b0;
      r_iss_op  <= 1'b0;
      r_iss_x   <= '0;
      r_iss_tag <= '0;
      r_iss_id  <= '0;
    end else begin
      r_iss_vld <= w_gnt_any;
      if (w_gnt_any) begin
        r_ptr     <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
        r_iss_op  <= w_sel_op;
        r_iss_x   <= w_sel_x;
        r_iss_tag <= w_sel_tag;
        r_iss_id  <= w_gnt_idx;
      end
    end
  end

  assign cvt_issue = r_iss_vld;
  assign cvt_op    = r_iss_op;
  assign cvt_x     = r_iss_x;

  logic            w_tail_vld;
  logic [IDW-1:0]  w_tail_id;
  logic [TAGW-1:0] w_tail_tag;
  logic            w_pipe_any;

  generate
    if (CVT_LAT == 0) begin : g_nopipe
      assign w_tail_vld = r_iss_vld;
      assign w_tail_id  = r_iss_id;
      assign w_tail_tag = r_iss_tag;
      assign w_pipe_any = 1'b0;
    end else begin : g_pipe
      logic [CVT_LAT-1:0] r_pv;
      logic [IDW-1:0]     r_pid  [CVT_LAT];
      logic [TAGW-1:0]    r_ptag [CVT_LAT];

      // Tracking pipe mirrors the converter latency so the tail lines up with cvt_y.
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
          r_pv <= '0;
          for (int s = 0; s < CVT_LAT; s++) begin
            r_pid[s]  <= '0;
            r_ptag[s] <= '0;
          end
        end else begin
          r_pv[0]   <= r_iss_vld & ~flush;
          r_pid[0]  <= r_iss_id;
          r_ptag[0] <= r_iss_tag;
          for (int s = 1; s < CVT_LAT; s++) begin
            r_pv[s]   <= r_pv[s-1] & ~flush;
            r_pid[s]  <= r_pid[s-1];
            r_ptag[s] <= r_ptag[s-1];
          end
        end
      end

      assign w_tail_vld = r_pv[CVT_LAT-1];
      assign w_tail_id  = r_pid[CVT_LAT-1];
      assign w_tail_tag = r_ptag[CVT_LAT-1];
      assign w_pipe_any = |r_pv;
    end
  endgenerate

  logic [NREQ-1:0] r_rsp_vld;
  logic [31:0]     r_rsp_y;
  logic [TAGW-1:0] r_rsp_tag;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_rsp_vld <= '0;
      r_rsp_y   <= '0;
      r_rsp_tag <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        r_rsp_vld[i] <= w_tail_vld && !flush && (w_tail_id == IDW'(i));
      if (w_tail_vld) begin
        r_rsp_y   <= cvt_y;
        r_rsp_tag <= w_tail_tag;
      end
    end
  end

  assign rsp_valid = r_rsp_vld;
  assign rsp_y     = r_rsp_y;
  assign rsp_tag   = r_rsp_tag;
  assign idle      = ~(r_iss_vld | w_pipe_any | (|r_rsp_vld));

endmodule

// File: tb/tb_fcvt_sched.sv
// Directed bench for fcvt_sched: a 2-requester combinational-converter
// instance and a 3-requester instance behind a 3-cycle converter.
module tb_fcvt_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Stand-in converter: exact values for the directed cases, arbitrary mapping otherwise.
  function automatic logic [31:0] cvt_model(input logic op, input logic [31:0] x);
    logic [31:0] y;
    if (!op) begin
      case (x)
        32'd1:         y = 32'h3F80_0000;
        32'd2:         y = 32'h4000_0000;
        32'd3:         y = 32'h4040_0000;
        32'd4:         y = 32'h4080_0000;
        32'd5:         y = 32'h40A0_0000;
        32'h8000_0000: y = 32'hCF00_0000;
        default:       y = x ^ 32'h5A5A_5A5A;
      endcase
    end else begin
      case (x)
        32'h40A0_0000: y = 32'd5;
        default:       y = x ^ 32'hA5A5_A5A5;
      endcase
    end
    return y;
  endfunction

  logic [1:0]  a_req_valid, a_req_ready, a_req_op, a_rsp_valid;
  logic [63:0] a_req_x;
  logic [9:0]  a_req_tag;
  logic        a_flush, a_cvt_issue, a_cvt_op, a_idle;
  logic [31:0] a_cvt_x, a_cvt_y, a_rsp_y;
  logic [4:0]  a_rsp_tag;

  assign a_cvt_y = cvt_model(a_cvt_op, a_cvt_x);

  fcvt_sched #(.NREQ(2), .CVT_LAT(0), .TAGW(5)) u_dut_a (
    .clk(clk), .rstn(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .req_x(a_req_x), .req_tag(a_req_tag), .flush(a_flush),
    .cvt_issue(a_cvt_issue), .cvt_op(a_cvt_op), .cvt_x(a_cvt_x), .cvt_y(a_cvt_y),
    .rsp_valid(a_rsp_valid), .rsp_y(a_rsp_y), .rsp_tag(a_rsp_tag), .idle(a_idle)
  );

  logic [2:0]  b_req_valid, b_req_ready, b_req_op, b_rsp_valid;
  logic [95:0] b_req_x;
  logic [14:0] b_req_tag;
  logic        b_flush, b_cvt_issue, b_cvt_op, b_idle;
  logic [31:0] b_cvt_x, b_cvt_y, b_rsp_y;
  logic [4:0]  b_rsp_tag;
  logic [31:0] b_s1, b_s2, b_s3;

  always @(posedge clk) begin
    b_s1 <= cvt_model(b_cvt_op, b_cvt_x);
    b_s2 <= b_s1;
    b_s3 <= b_s2;
  end
  assign b_cvt_y = b_s3;

  fcvt_sched #(.NREQ(3), .CVT_LAT(3), .TAGW(5)) u_dut_b (
    .clk(clk), .rstn(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_x(b_req_x), .req_tag(b_req_tag), .flush(b_flush),
    .cvt_issue(b_cvt_issue), .cvt_op(b_cvt_op), .cvt_x(b_cvt_x), .cvt_y(b_cvt_y),
    .rsp_valid(b_rsp_valid), .rsp_y(b_rsp_y), .rsp_tag(b_rsp_tag), .idle(b_idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic a_single(input logic op, input logic [31:0] x, input logic [4:0] tag,
                          input logic [31:0] ey, input string nm);
    a_req_valid      = 2'b01;
    a_req_op         = {1'b0, op};
    a_req_x[31:0]    = x;
    a_req_tag[4:0]   = tag;
    #1;
    chk({nm, "_ready"}, a_req_ready, 2'b01);
    step;
    a_req_valid = 2'b00;
    chk({nm, "_issue"}, a_cvt_issue, 1);
    chk({nm, "_cvt_x"}, a_cvt_x, x);
    chk({nm, "_cvt_op"}, a_cvt_op, op);
    chk({nm, "_early"}, a_rsp_valid, 0);
    step;
    chk({nm, "_rsp_valid"}, a_rsp_valid, 2'b01);
    chk({nm, "_rsp_y"}, a_rsp_y, ey);
    chk({nm, "_rsp_tag"}, a_rsp_tag, tag);
    step;
    chk({nm, "_rsp_drop"}, a_rsp_valid, 0);
    chk({nm, "_idle"}, a_idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_y [4];
    logic [2:0]  seen;
    int g, pg;
    exp_y = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    a_req_valid = '0; a_req_op = '0; a_req_x = '0; a_req_tag = '0; a_flush = 1'b0;
    b_req_valid = '0; b_req_op = '0; b_req_x = '0; b_req_tag = '0; b_flush = 1'b0;

    #1 rst = 1'b1;
    a_req_valid = 2'b11;
    b_req_valid = 3'b111;
    #1;
    chk("rst_ready_a", a_req_ready, 0);
    chk("rst_ready_b", b_req_ready, 0);
    chk("rst_issue", a_cvt_issue, 0);
    chk("rst_cvt_x", a_cvt_x, 0);
    chk("rst_cvt_op", a_cvt_op, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_y", a_rsp_y, 0);
    chk("rst_rsp_tag", a_rsp_tag, 0);
    chk("rst_idle", a_idle, 1);
    a_req_valid = '0;
    b_req_valid = '0;
    @(negedge clk) rst = 1'b0;

    a_single(1'b0, 32'd5,         5'd3, 32'h40A0_0000, "itof5");
    a_single(1'b1, 32'h40A0_0000, 5'd4, 32'd5,         "ftoi5");
    a_single(1'b0, 32'h8000_0000, 5'd5, 32'hCF00_0000, "itof_min");

    // Both requesters held: ptr sits at 1 after the req0-only ops above.
    a_req_op    = 2'b00;
    a_req_x     = {32'd200, 32'd100};
    a_req_tag   = {5'd20, 5'd10};
    a_req_valid = 2'b11;
    #1;
    for (int k = 0; k < 8; k++) begin
      g = (k % 2 == 0) ? 1 : 0;
      chk("rr_ready", a_req_ready, 32'(1 << g));
      step;
      if (k > 0) begin
        pg = 1 - g;
        chk("rr_rsp_valid", a_rsp_valid, 32'(1 << pg));
        chk("rr_rsp_tag", a_rsp_tag, (pg == 1) ? 32'd20 : 32'd10);
        chk("rr_rsp_y", a_rsp_y, cvt_model(1'b0, (pg == 1) ? 32'd200 : 32'd100));
      end
    end
    a_req_valid = 2'b00;
    step;
    chk("rr_last_valid", a_rsp_valid, 2'b01);
    chk("rr_last_tag", a_rsp_tag, 10);
    step;

    a_req_valid = 2'b01;
    a_flush     = 1'b1;
    #1;
    chk("flushreq_ready", a_req_ready, 0);
    step;
    a_flush = 1'b0;
    #1;
    chk("flushreq_no_issue", a_cvt_issue, 0);
    chk("flushreq_next_ready", a_req_ready, 2'b01);
    step;
    a_req_valid = 2'b00;
    chk("flushreq_issue", a_cvt_issue, 1);
    step;
    chk("flushreq_rsp", a_rsp_valid, 2'b01);
    step;

    // Requester 1 back-to-back through the 3-cycle converter.
    b_req_op = 3'b000;
    for (int e = 0; e < 8; e++) begin
      if (e < 4) begin
        b_req_valid     = 3'b010;
        b_req_x[63:32]  = 32'(e + 1);
        b_req_tag[9:5]  = 5'(e);
      end else begin
        b_req_valid = 3'b000;
      end
      step;
      if (e >= 4) begin
        chk("b2b_rsp_valid", b_rsp_valid, 3'b010);
        chk("b2b_rsp_y", b_rsp_y, exp_y[e-4]);
        chk("b2b_rsp_tag", b_rsp_tag, 32'(e - 4));
      end else begin
        chk("b2b_rsp_quiet", b_rsp_valid, 0);
      end
    end

    // Three requesters held with ptr at 2: grants 2,0,1,2.
    b_req_x     = {32'd30, 32'd20, 32'd10};
    b_req_tag   = {5'd22, 5'd21, 5'd20};
    b_req_valid = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr3_ready", b_req_ready, 32'(1 << ((2 + k) % 3)));
      step;
    end
    b_req_valid = 3'b000;
    repeat (6) step;
    chk("rr3_idle", b_idle, 1);

    for (int j = 0; j < 3; j++) begin
      b_req_valid    = 3'b001;
      b_req_x[31:0]  = 32'(j + 1);
      b_req_tag[4:0] = 5'(j);
      step;
    end
    b_req_valid = 3'b000;
    step;
    chk("flush_busy", b_idle, 0);
    b_flush = 1'b1;
    step;
    b_flush = 1'b0;
    chk("flush_idle", b_idle, 1);
    chk("flush_rsp_now", b_rsp_valid, 0);
    seen = '0;
    repeat (6) begin
      step;
      seen = seen | b_rsp_valid;
    end
    chk("flush_no_rsp", seen, 0);

    b_req_valid      = 3'b100;
    b_req_x[95:64]   = 32'd3;
    b_req_tag[14:10] = 5'd7;
    #1;
    chk("postflush_ready", b_req_ready, 3'b100);
    step;
    b_req_valid = 3'b000;
    repeat (3) step;
    chk("postflush_early", b_rsp_valid, 0);
    step;
    chk("postflush_valid", b_rsp_valid, 3'b100);
    chk("postflush_y", b_rsp_y, 32'h4040_0000);
    chk("postflush_tag", b_rsp_tag, 7);
    step;

    // Two ops in flight, then asynchronous reset away from the clock edge.
    b_req_valid    = 3'b001;
    b_req_x[31:0]  = 32'd1;
    b_req_tag[4:0] = 5'd1;
    step;
    b_req_x[31:0]  = 32'd2;
    b_req_tag[4:0] = 5'd2;
    step;
    b_req_valid = 3'b000;
    #1 rst = 1'b1;
    b_req_valid = 3'b111;
    #1;
    chk("arst_ready", b_req_ready, 0);
    chk("arst_issue", b_cvt_issue, 0);
    chk("arst_cvt_x", b_cvt_x, 0);
    chk("arst_rsp_valid", b_rsp_valid, 0);
    chk("arst_rsp_y", b_rsp_y, 0);
    chk("arst_idle", b_idle, 1);
    b_req_valid = 3'b000;
    @(negedge clk) rst = 1'b0;
    seen = '0;
    repeat (6) begin
      step;
      seen = seen | b_rsp_valid;
    end
    chk("arst_no_rsp", seen, 0);
    b_req_valid = 3'b111;
    #1;
    chk("arst_ptr", b_req_ready, 3'b001);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
